// File: rtl/dispatcher.sv
// Dispatcher: single-entry hold stage between the decoder and the RS/LSB/ROB.
// An accepted instruction waits in the hold register until the ROB and its
// target station (RS for ALU ops, LSB for loads/stores) have room. When it
// fires, it allocates a ROB entry, renames rd, resolves both source operands
// and drives a registered issue packet on the next edge.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   rdy                  global enable; low freezes all state
//   clear                flush; drops the held instruction and all strobes
//   inst_*               decoder handshake and instruction fields
//   rf_*                 regfile read addresses (comb), values/busy/tags in
//   rename_*             rd rename request toward the regfile
//   rob_*                ROB status, source-tag lookup and allocation
//   rs_full, lsb_full    station back-pressure
//   is_issue, lsb_issue  one-cycle issue strobes; issue_* shared payload
//   is_alu_ok/is_lsb_ok  CDB broadcasts used for same-cycle forwarding
module dispatcher (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clear,
  // Decoder side
  input  logic        inst_valid,
  output logic        inst_ready,
  input  logic [5:0]  inst_opcode,
  input  logic [4:0]  inst_rd,
  input  logic [4:0]  inst_rs1,
  input  logic [4:0]  inst_rs2,
  input  logic        inst_use_rs1,
  input  logic        inst_use_rs2,
  input  logic        inst_wr_rd,
  input  logic        inst_is_ls,
  input  logic [31:0] inst_imm,
  input  logic [31:0] inst_pc,
  // Regfile side
  output logic [4:0]  rf_rs1,
  output logic [4:0]  rf_rs2,
  input  logic [31:0] rf_val1,
  input  logic [31:0] rf_val2,
  input  logic        rf_busy1,
  input  logic        rf_busy2,
  input  logic [3:0]  rf_tag1,
  input  logic [3:0]  rf_tag2,
  output logic        rename_en,
  output logic [4:0]  rename_rd,
  output logic [3:0]  rename_tag,
  // ROB side
  input  logic        rob_full,
  input  logic [3:0]  rob_tail,
  output logic [3:0]  rob_q1,
  output logic [3:0]  rob_q2,
  input  logic        rob_rdy1,
  input  logic        rob_rdy2,
  input  logic [31:0] rob_val1,
  input  logic [31:0] rob_val2,
  output logic        rob_alloc_en,
  output logic [5:0]  rob_opcode,
  output logic [4:0]  rob_rd,
  output logic [31:0] rob_pc,
  // RS / LSB side
  input  logic        rs_full,
  input  logic        lsb_full,
  output logic        is_issue,
  output logic        lsb_issue,
  output logic [5:0]  issue_opcode,
  output logic [3:0]  issue_rob_id,
  output logic [31:0] issue_Vi,
  output logic [31:0] issue_Vj,
  output logic [3:0]  issue_Qi,
  output logic [3:0]  issue_Qj,
  output logic        issue_Ri,
  output logic        issue_Rj,
  output logic [31:0] issue_imm,
  output logic [31:0] issue_pc,
  // Broadcast
  input  logic        is_alu_ok,
  input  logic        is_lsb_ok,
  input  logic [3:0]  rob_id_from_alu,
  input  logic [3:0]  rob_id_from_lsb,
  input  logic [31:0] res_from_alu,
  input  logic [31:0] res_from_lsb
);

  typedef enum logic [0:0] {StEmpty, StHeld} state_e;

  state_e      state_q, state_d;

  // Hold register fields
  logic [5:0]  hold_opcode_q, hold_opcode_d;
  logic [4:0]  hold_rd_q, hold_rd_d;
  logic [4:0]  hold_rs1_q, hold_rs1_d;
  logic [4:0]  hold_rs2_q, hold_rs2_d;
  logic        hold_use_rs1_q, hold_use_rs1_d;
  logic        hold_use_rs2_q, hold_use_rs2_d;
  logic        hold_wr_rd_q, hold_wr_rd_d;
  logic        hold_is_ls_q, hold_is_ls_d;
  logic [31:0] hold_imm_q, hold_imm_d;
  logic [31:0] hold_pc_q, hold_pc_d;

  // Registered outputs
  logic        is_issue_q, is_issue_d;
  logic        lsb_issue_q, lsb_issue_d;
  logic        rob_alloc_en_q, rob_alloc_en_d;
  logic        rename_en_q, rename_en_d;
  logic [4:0]  rename_rd_q, rename_rd_d;
  logic [3:0]  rename_tag_q, rename_tag_d;
  logic [5:0]  rob_opcode_q, rob_opcode_d;
  logic [4:0]  rob_rd_q, rob_rd_d;
  logic [31:0] rob_pc_q, rob_pc_d;
  logic [5:0]  issue_opcode_q, issue_opcode_d;
  logic [3:0]  issue_rob_id_q, issue_rob_id_d;
  logic [31:0] issue_vi_q, issue_vi_d;
  logic [31:0] issue_vj_q, issue_vj_d;
  logic [3:0]  issue_qi_q, issue_qi_d;
  logic [3:0]  issue_qj_q, issue_qj_d;
  logic        issue_ri_q, issue_ri_d;
  logic        issue_rj_q, issue_rj_d;
  logic [31:0] issue_imm_q, issue_imm_d;
  logic [31:0] issue_pc_q, issue_pc_d;

  logic        hold_valid;
  logic        target_full;
  logic        fire;
  logic        accept;
  logic [36:0] op1;
  logic [36:0] op2;

  // Returns {ready, tag, value}. Forwarding from the CDB covers a producer
  // completing in the very cycle the consumer fires.
  function automatic logic [36:0] resolve_op(
    input logic        use_rs,
    input logic [4:0]  rs,
    input logic        busy,
    input logic [31:0] rf_val,
    input logic [3:0]  tag,
    input logic        rob_ok,
    input logic [31:0] rob_val,
    input logic        alu_ok,
    input logic [3:0]  alu_id,
    input logic [31:0] alu_res,
    input logic        lsb_ok,
    input logic [3:0]  lsb_id,
    input logic [31:0] lsb_res
  );
    logic [36:0] res;
    if (!use_rs || rs == 5'd0) begin
      res = {1'b1, 4'd0, 32'd0};
    end else if (!busy) begin
      res = {1'b1, 4'd0, rf_val};
    end else if (alu_ok && alu_id == tag) begin
      res = {1'b1, 4'd0, alu_res};
    end else if (lsb_ok && lsb_id == tag) begin
      res = {1'b1, 4'd0, lsb_res};
    end else if (rob_ok) begin
      res = {1'b1, 4'd0, rob_val};
    end else begin
      res = {1'b0, tag, 32'd0};
    end
    return res;
  endfunction

  always_comb begin
    hold_valid  = (state_q == StHeld);
    target_full = hold_is_ls_q ? lsb_full : rs_full;
    fire        = hold_valid && rdy && !clear && !rob_full && !target_full;
    inst_ready  = !hold_valid || fire;
    accept      = inst_valid && inst_ready && rdy && !clear;
    op1 = resolve_op(hold_use_rs1_q, hold_rs1_q, rf_busy1, rf_val1, rf_tag1, rob_rdy1,
                     rob_val1, is_alu_ok, rob_id_from_alu, res_from_alu, is_lsb_ok,
                     rob_id_from_lsb, res_from_lsb);
    op2 = resolve_op(hold_use_rs2_q, hold_rs2_q, rf_busy2, rf_val2, rf_tag2, rob_rdy2,
                     rob_val2, is_alu_ok, rob_id_from_alu, res_from_alu, is_lsb_ok,
                     rob_id_from_lsb, res_from_lsb);
  end

  always_comb begin
    state_d        = state_q;
    hold_opcode_d  = hold_opcode_q;
    hold_rd_d      = hold_rd_q;
    hold_rs1_d     = hold_rs1_q;
    hold_rs2_d     = hold_rs2_q;
    hold_use_rs1_d = hold_use_rs1_q;
    hold_use_rs2_d = hold_use_rs2_q;
    hold_wr_rd_d   = hold_wr_rd_q;
    hold_is_ls_d   = hold_is_ls_q;
    hold_imm_d     = hold_imm_q;
    hold_pc_d      = hold_pc_q;
    is_issue_d     = is_issue_q;
    lsb_issue_d    = lsb_issue_q;
    rob_alloc_en_d = rob_alloc_en_q;
    rename_en_d    = rename_en_q;
    rename_rd_d    = rename_rd_q;
    rename_tag_d   = rename_tag_q;
    rob_opcode_d   = rob_opcode_q;
    rob_rd_d       = rob_rd_q;
    rob_pc_d       = rob_pc_q;
    issue_opcode_d = issue_opcode_q;
    issue_rob_id_d = issue_rob_id_q;
    issue_vi_d     = issue_vi_q;
    issue_vj_d     = issue_vj_q;
    issue_qi_d     = issue_qi_q;
    issue_qj_d     = issue_qj_q;
    issue_ri_d     = issue_ri_q;
    issue_rj_d     = issue_rj_q;
    issue_imm_d    = issue_imm_q;
    issue_pc_d     = issue_pc_q;

    if (clear) begin
      // Flush wins over the enable so a mispredict is never held off.
      state_d        = StEmpty;
      is_issue_d     = 1'b0;
      lsb_issue_d    = 1'b0;
      rob_alloc_en_d = 1'b0;
      rename_en_d    = 1'b0;
    end else if (rdy) begin
      is_issue_d     = fire && !hold_is_ls_q;
      lsb_issue_d    = fire && hold_is_ls_q;
      rob_alloc_en_d = fire;
      rename_en_d    = fire && hold_wr_rd_q && (hold_rd_q != 5'd0);

      if (fire) begin
        rename_rd_d    = hold_rd_q;
        rename_tag_d   = rob_tail;
        rob_opcode_d   = hold_opcode_q;
        rob_rd_d       = hold_rd_q;
        rob_pc_d       = hold_pc_q;
        issue_opcode_d = hold_opcode_q;
        issue_rob_id_d = rob_tail;
        issue_ri_d     = op1[36];
        issue_qi_d     = op1[35:32];
        issue_vi_d     = op1[31:0];
        issue_rj_d     = op2[36];
        issue_qj_d     = op2[35:32];
        issue_vj_d     = op2[31:0];
        issue_imm_d    = hold_imm_q;
        issue_pc_d     = hold_pc_q;
      end

      if (accept) begin
        state_d        = StHeld;
        hold_opcode_d  = inst_opcode;
        hold_rd_d      = inst_rd;
        hold_rs1_d     = inst_rs1;
        hold_rs2_d     = inst_rs2;
        hold_use_rs1_d = inst_use_rs1;
        hold_use_rs2_d = inst_use_rs2;
        hold_wr_rd_d   = inst_wr_rd;
        hold_is_ls_d   = inst_is_ls;
        hold_imm_d     = inst_imm;
        hold_pc_d      = inst_pc;
      end else if (fire) begin
        state_d = StEmpty;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StEmpty;
      hold_opcode_q  <= '0;
      hold_rd_q      <= '0;
      hold_rs1_q     <= '0;
      hold_rs2_q     <= '0;
      hold_use_rs1_q <= 1'b0;
      hold_use_rs2_q <= 1'b0;
      hold_wr_rd_q   <= 1'b0;
      hold_is_ls_q   <= 1'b0;
      hold_imm_q     <= '0;
      hold_pc_q      <= '0;
      is_issue_q     <= 1'b0;
      lsb_issue_q    <= 1'b0;
      rob_alloc_en_q <= 1'b0;
      rename_en_q    <= 1'b0;
      rename_rd_q    <= '0;
      rename_tag_q   <= '0;
      rob_opcode_q   <= '0;
      rob_rd_q       <= '0;
      rob_pc_q       <= '0;
      issue_opcode_q <= '0;
      issue_rob_id_q <= '0;
      issue_vi_q     <= '0;
      issue_vj_q     <= '0;
      issue_qi_q     <= '0;
      issue_qj_q     <= '0;
      issue_ri_q     <= 1'b0;
      issue_rj_q     <= 1'b0;
      issue_imm_q    <= '0;
      issue_pc_q     <= '0;
    end else begin
      state_q        <= state_d;
      hold_opcode_q  <= hold_opcode_d;
      hold_rd_q      <= hold_rd_d;
      hold_rs1_q     <= hold_rs1_d;
      hold_rs2_q     <= hold_rs2_d;
      hold_use_rs1_q <= hold_use_rs1_d;
      hold_use_rs2_q <= hold_use_rs2_d;
      hold_wr_rd_q   <= hold_wr_rd_d;
      hold_is_ls_q   <= hold_is_ls_d;
      hold_imm_q     <= hold_imm_d;
      hold_pc_q      <= hold_pc_d;
      is_issue_q     <= is_issue_d;
      lsb_issue_q    <= lsb_issue_d;
      rob_alloc_en_q <= rob_alloc_en_d;
      rename_en_q    <= rename_en_d;
      rename_rd_q    <= rename_rd_d;
      rename_tag_q   <= rename_tag_d;
      rob_opcode_q   <= rob_opcode_d;
      rob_rd_q       <= rob_rd_d;
      rob_pc_q       <= rob_pc_d;
      issue_opcode_q <= issue_opcode_d;
      issue_rob_id_q <= issue_rob_id_d;
      issue_vi_q     <= issue_vi_d;
      issue_vj_q     <= issue_vj_d;
      issue_qi_q     <= issue_qi_d;
      issue_qj_q     <= issue_qj_d;
      issue_ri_q     <= issue_ri_d;
      issue_rj_q     <= issue_rj_d;
      issue_imm_q    <= issue_imm_d;
      issue_pc_q     <= issue_pc_d;
    end
  end

  assign rf_rs1       = hold_rs1_q;
  assign rf_rs2       = hold_rs2_q;
  assign rob_q1       = rf_tag1;
  assign rob_q2       = rf_tag2;
  assign is_issue     = is_issue_q;
  assign lsb_issue    = lsb_issue_q;
  assign rob_alloc_en = rob_alloc_en_q;
  assign rename_en    = rename_en_q;
  assign rename_rd    = rename_rd_q;
  assign rename_tag   = rename_tag_q;
  assign rob_opcode   = rob_opcode_q;
  assign rob_rd       = rob_rd_q;
  assign rob_pc       = rob_pc_q;
  assign issue_opcode = issue_opcode_q;
  assign issue_rob_id = issue_rob_id_q;
  assign issue_Vi     = issue_vi_q;
  assign issue_Vj     = issue_vj_q;
  assign issue_Qi     = issue_qi_q;
  assign issue_Qj     = issue_qj_q;
  assign issue_Ri     = issue_ri_q;
  assign issue_Rj     = issue_rj_q;
  assign issue_imm    = issue_imm_q;
  assign issue_pc     = issue_pc_q;

endmodule

// File: tb/tb_dispatcher.sv
// Self-checking bench for the dispatcher: directed scenarios followed by a
// randomized run compared against a transaction-level reference model.
module tb_dispatcher;

  logic        clk = 1'b0;
  logic        rst, rdy, clear;
  logic        inst_valid, inst_ready;
  logic [5:0]  inst_opcode;
  logic [4:0]  inst_rd, inst_rs1, inst_rs2;
  logic        inst_use_rs1, inst_use_rs2, inst_wr_rd, inst_is_ls;
  logic [31:0] inst_imm, inst_pc;
  logic [4:0]  rf_rs1, rf_rs2;
  logic [31:0] rf_val1, rf_val2;
  logic        rf_busy1, rf_busy2;
  logic [3:0]  rf_tag1, rf_tag2;
  logic        rename_en;
  logic [4:0]  rename_rd;
  logic [3:0]  rename_tag;
  logic        rob_full;
  logic [3:0]  rob_tail, rob_q1, rob_q2;
  logic        rob_rdy1, rob_rdy2;
  logic [31:0] rob_val1, rob_val2;
  logic        rob_alloc_en;
  logic [5:0]  rob_opcode;
  logic [4:0]  rob_rd;
  logic [31:0] rob_pc;
  logic        rs_full, lsb_full, is_issue, lsb_issue;
  logic [5:0]  issue_opcode;
  logic [3:0]  issue_rob_id;
  logic [31:0] issue_Vi, issue_Vj;
  logic [3:0]  issue_Qi, issue_Qj;
  logic        issue_Ri, issue_Rj;
  logic [31:0] issue_imm, issue_pc;
  logic        is_alu_ok, is_lsb_ok;
  logic [3:0]  rob_id_from_alu, rob_id_from_lsb;
  logic [31:0] res_from_alu, res_from_lsb;

  int errors = 0;
  int checks = 0;

  dispatcher dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_opcode(inst_opcode),
    .inst_rd(inst_rd), .inst_rs1(inst_rs1), .inst_rs2(inst_rs2),
    .inst_use_rs1(inst_use_rs1), .inst_use_rs2(inst_use_rs2), .inst_wr_rd(inst_wr_rd),
    .inst_is_ls(inst_is_ls), .inst_imm(inst_imm), .inst_pc(inst_pc),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_val1(rf_val1), .rf_val2(rf_val2),
    .rf_busy1(rf_busy1), .rf_busy2(rf_busy2), .rf_tag1(rf_tag1), .rf_tag2(rf_tag2),
    .rename_en(rename_en), .rename_rd(rename_rd), .rename_tag(rename_tag),
    .rob_full(rob_full), .rob_tail(rob_tail), .rob_q1(rob_q1), .rob_q2(rob_q2),
    .rob_rdy1(rob_rdy1), .rob_rdy2(rob_rdy2), .rob_val1(rob_val1), .rob_val2(rob_val2),
    .rob_alloc_en(rob_alloc_en), .rob_opcode(rob_opcode), .rob_rd(rob_rd), .rob_pc(rob_pc),
    .rs_full(rs_full), .lsb_full(lsb_full), .is_issue(is_issue), .lsb_issue(lsb_issue),
    .issue_opcode(issue_opcode), .issue_rob_id(issue_rob_id),
    .issue_Vi(issue_Vi), .issue_Vj(issue_Vj), .issue_Qi(issue_Qi), .issue_Qj(issue_Qj),
    .issue_Ri(issue_Ri), .issue_Rj(issue_Rj), .issue_imm(issue_imm), .issue_pc(issue_pc),
    .is_alu_ok(is_alu_ok), .is_lsb_ok(is_lsb_ok),
    .rob_id_from_alu(rob_id_from_alu), .rob_id_from_lsb(rob_id_from_lsb),
    .res_from_alu(res_from_alu), .res_from_lsb(res_from_lsb)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs are read there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; rdy = 1; clear = 0; inst_valid = 0; inst_opcode = 0; inst_rd = 0;
    inst_rs1 = 0; inst_rs2 = 0; inst_use_rs1 = 0; inst_use_rs2 = 0; inst_wr_rd = 0;
    inst_is_ls = 0; inst_imm = 0; inst_pc = 0; rf_val1 = 0; rf_val2 = 0; rf_busy1 = 0;
    rf_busy2 = 0; rf_tag1 = 0; rf_tag2 = 0; rob_full = 0; rob_tail = 0; rob_rdy1 = 0;
    rob_rdy2 = 0; rob_val1 = 0; rob_val2 = 0; rs_full = 0; lsb_full = 0; is_alu_ok = 0;
    is_lsb_ok = 0; rob_id_from_alu = 0; rob_id_from_lsb = 0; res_from_alu = 0;
    res_from_lsb = 0;
  endtask

  task automatic drive_inst(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic wr, input logic ls,
                            input logic [31:0] imm, input logic [31:0] pc);
    inst_valid = 1; inst_opcode = op; inst_rd = rd; inst_rs1 = rs1; inst_rs2 = rs2;
    inst_use_rs1 = 1; inst_use_rs2 = 1; inst_wr_rd = wr; inst_is_ls = ls;
    inst_imm = imm; inst_pc = pc;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    step(); step();
    rst = 0;
    #1;
    checks++;
    if ({is_issue, lsb_issue, rob_alloc_en, rename_en} !== 4'b0) begin
      errors++; $display("FAIL reset_strobes: got %b exp 0000",
                         {is_issue, lsb_issue, rob_alloc_en, rename_en});
    end
    checks++;
    if ({issue_Vi, issue_Vj, issue_pc, issue_imm, rob_pc} !== 160'd0 ||
        {issue_rob_id, issue_Qi, issue_Qj, rename_tag, rename_rd, rob_rd} !== 26'd0) begin
      errors++; $display("FAIL reset_data: data outputs not zero (Vi=%0h pc=%0h id=%0h)",
                         issue_Vi, issue_pc, issue_rob_id);
    end
    checks++;
    if (inst_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b exp 1", inst_ready);
    end
  endtask

  // Held ALU op: rs1 ready in the regfile, rs2 waits on tag 3, optionally forwarded.
  task automatic test_alu_operands(input logic fwd);
    idle_inputs();
    drive_inst(6'h05, 5'd9, 5'd1, 5'd2, 1, 0, 32'hABCD, 32'h400);
    step();
    inst_valid = 0;
    rf_val1 = 32'd5; rf_busy2 = 1; rf_tag2 = 4'd3; rob_tail = 4'd7;
    if (fwd) begin
      is_alu_ok = 1; rob_id_from_alu = 4'd3; res_from_alu = 32'h10;
    end
    #1;
    checks++;
    if (rf_rs1 !== 5'd1 || rf_rs2 !== 5'd2 || rob_q2 !== 4'd3) begin
      errors++; $display("FAIL op_lookup: rs1=%0d rs2=%0d q2=%0d exp 1 2 3",
                         rf_rs1, rf_rs2, rob_q2);
    end
    step();
    idle_inputs();
    checks++;
    if (is_issue !== 1 || lsb_issue !== 0 || rob_alloc_en !== 1 || issue_rob_id !== 4'd7) begin
      errors++; $display("FAIL op_issue: is=%b lsb=%b alloc=%b id=%0d exp 1 0 1 7",
                         is_issue, lsb_issue, rob_alloc_en, issue_rob_id);
    end
    checks++;
    if (issue_Vi !== 32'd5 || issue_Ri !== 1 || issue_Qi !== 4'd0) begin
      errors++; $display("FAIL op_rs1: Vi=%0h Ri=%b Qi=%0d exp 5 1 0",
                         issue_Vi, issue_Ri, issue_Qi);
    end
    checks++;
    if (!fwd && (issue_Rj !== 0 || issue_Qj !== 4'd3 || issue_Vj !== 32'd0)) begin
      errors++; $display("FAIL op_rs2_wait: Rj=%b Qj=%0d Vj=%0h exp 0 3 0",
                         issue_Rj, issue_Qj, issue_Vj);
    end else if (fwd && (issue_Rj !== 1 || issue_Qj !== 4'd0 || issue_Vj !== 32'h10)) begin
      errors++; $display("FAIL op_rs2_fwd: Rj=%b Qj=%0d Vj=%0h exp 1 0 10",
                         issue_Rj, issue_Qj, issue_Vj);
    end
    checks++;
    if (rename_en !== 1 || rename_rd !== 5'd9 || rename_tag !== 4'd7 ||
        issue_imm !== 32'hABCD || issue_pc !== 32'h400 || issue_opcode !== 6'h05 ||
        rob_opcode !== 6'h05 || rob_rd !== 5'd9 || rob_pc !== 32'h400) begin
      errors++; $display("FAIL op_fields: ren=%b rd=%0d tag=%0d imm=%0h pc=%0h op=%0h",
                         rename_en, rename_rd, rename_tag, issue_imm, issue_pc, issue_opcode);
    end
    step();
    checks++;
    if (is_issue !== 0 || rob_alloc_en !== 0) begin
      errors++; $display("FAIL op_single_pulse: is=%b alloc=%b exp 0 0", is_issue, rob_alloc_en);
    end
  endtask

  task automatic test_lsb_stall();
    int pulses;
    idle_inputs();
    lsb_full = 1;
    drive_inst(6'h03, 5'd4, 5'd1, 5'd0, 1, 1, 32'h8, 32'h500);
    step();
    inst_valid = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (inst_ready !== 0) begin
        errors++; $display("FAIL lsb_stall_ready: cycle %0d got %b exp 0", i, inst_ready);
      end
      step();
      checks++;
      if ({is_issue, lsb_issue, rob_alloc_en, rename_en} !== 4'b0) begin
        errors++; $display("FAIL lsb_stall_strobes: cycle %0d got %b exp 0000", i,
                           {is_issue, lsb_issue, rob_alloc_en, rename_en});
      end
    end
    lsb_full = 0;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (lsb_issue === 1) pulses++;
      checks++;
      if (is_issue !== 0) begin
        errors++; $display("FAIL lsb_wrong_station: is_issue=%b exp 0", is_issue);
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++; $display("FAIL lsb_pulses: got %0d exp 1", pulses);
    end
  endtask

  task automatic test_rob_full();
    idle_inputs();
    rob_full = 1;
    drive_inst(6'h01, 5'd2, 5'd0, 5'd0, 1, 0, 0, 32'h600);
    step();
    inst_valid = 0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (rob_alloc_en !== 0 || is_issue !== 0) begin
        errors++; $display("FAIL rob_full_stall: alloc=%b is=%b exp 0 0", rob_alloc_en, is_issue);
      end
    end
    rob_full = 0;
    step();
    checks++;
    if (rob_alloc_en !== 1 || is_issue !== 1) begin
      errors++; $display("FAIL rob_full_release: alloc=%b is=%b exp 1 1", rob_alloc_en, is_issue);
    end
    step();
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    for (int i = 0; i < 6; i++) begin
      if (i < 4) drive_inst(6'h02, 5'(i + 1), 5'd0, 5'd0, 1, 0, 32'(i), 32'(32'h700 + 4 * i));
      else inst_valid = 0;
      rob_tail = (i >= 1) ? 4'(i - 1) : 4'd0;
      if (i >= 1 && i <= 3) begin
        #1;
        checks++;
        if (inst_ready !== 1) begin
          errors++; $display("FAIL b2b_ready: cycle %0d got %b exp 1", i, inst_ready);
        end
      end
      step();
      if (i >= 1 && i <= 4) begin
        checks++;
        if (is_issue !== 1 || issue_rob_id !== 4'(i - 1) ||
            issue_pc !== 32'(32'h700 + 4 * (i - 1))) begin
          errors++; $display("FAIL b2b_issue: cycle %0d is=%b id=%0d pc=%0h exp 1 %0d", i,
                             is_issue, issue_rob_id, issue_pc, i - 1);
        end
      end else if (i == 5) begin
        checks++;
        if (is_issue !== 0) begin
          errors++; $display("FAIL b2b_tail: is=%b exp 0", is_issue);
        end
      end
    end
  endtask

  task automatic test_clear();
    idle_inputs();
    rs_full = 1;
    drive_inst(6'h01, 5'd3, 5'd0, 5'd0, 1, 0, 0, 32'h800);
    step();
    drive_inst(6'h04, 5'd6, 5'd0, 5'd0, 1, 0, 0, 32'h804);
    rs_full = 0; clear = 1;
    step();
    checks++;
    if ({is_issue, lsb_issue, rob_alloc_en, rename_en} !== 4'b0) begin
      errors++; $display("FAIL clear_strobes: got %b exp 0000",
                         {is_issue, lsb_issue, rob_alloc_en, rename_en});
    end
    clear = 0; inst_valid = 0;
    #1;
    checks++;
    if (inst_ready !== 1) begin
      errors++; $display("FAIL clear_empty: inst_ready=%b exp 1", inst_ready);
    end
    step();
    checks++;
    if (is_issue !== 0 || rob_alloc_en !== 0) begin
      errors++; $display("FAIL clear_discard: is=%b alloc=%b exp 0 0", is_issue, rob_alloc_en);
    end
  endtask

  task automatic test_rd_zero();
    idle_inputs();
    drive_inst(6'h01, 5'd0, 5'd0, 5'd0, 1, 0, 0, 32'h900);
    step();
    inst_valid = 0;
    step();
    checks++;
    if (rob_alloc_en !== 1 || is_issue !== 1 || rename_en !== 0) begin
      errors++; $display("FAIL rd_zero: alloc=%b is=%b ren=%b exp 1 1 0",
                         rob_alloc_en, is_issue, rename_en);
    end
    step();
  endtask

  task automatic test_rst_mid_stall();
    idle_inputs();
    rs_full = 1; rob_tail = 4'd9;
    drive_inst(6'h01, 5'd5, 5'd0, 5'd0, 1, 0, 32'h11, 32'hA00);
    step();
    inst_valid = 0;
    step();
    rst = 1;
    step();
    rst = 0;
    #1;
    checks++;
    if ({is_issue, lsb_issue, rob_alloc_en, rename_en} !== 4'b0 || inst_ready !== 1) begin
      errors++; $display("FAIL rst_stall: strobes=%b ready=%b exp 0000 1",
                         {is_issue, lsb_issue, rob_alloc_en, rename_en}, inst_ready);
    end
    checks++;
    if (issue_pc !== 32'd0 || rob_pc !== 32'd0 || rename_tag !== 4'd0) begin
      errors++; $display("FAIL rst_data: pc=%0h rob_pc=%0h tag=%0d exp 0",
                         issue_pc, rob_pc, rename_tag);
    end
    rs_full = 0;
    step();
    checks++;
    if (is_issue !== 0) begin
      errors++; $display("FAIL rst_dropped: is=%b exp 0", is_issue);
    end
  endtask

  typedef struct packed {
    logic        r;
    logic [3:0]  q;
    logic [31:0] v;
  } opnd_t;

  function automatic opnd_t ref_operand(input logic use_rs, input logic [4:0] rs,
                                        input logic busy, input logic [31:0] val,
                                        input logic [3:0] tag, input logic robr,
                                        input logic [31:0] robv);
    opnd_t o;
    o = '{r: 1'b1, q: 4'd0, v: 32'd0};
    if (!use_rs || rs == 0) return o;
    if (!busy) o.v = val;
    else if (is_alu_ok && rob_id_from_alu == tag) o.v = res_from_alu;
    else if (is_lsb_ok && rob_id_from_lsb == tag) o.v = res_from_lsb;
    else if (robr) o.v = robv;
    else o = '{r: 1'b0, q: tag, v: 32'd0};
    return o;
  endfunction

  task automatic test_random();
    // Reference: a one-deep instruction queue plus the expected issue packet.
    logic        m_valid;
    logic [5:0]  m_op;
    logic [4:0]  m_rd, m_rs1, m_rs2;
    logic        m_u1, m_u2, m_wr, m_ls;
    logic [31:0] m_imm, m_pc;
    logic [3:0]  e_strobes;
    logic        fired, m_fire, m_ready, m_accept;
    logic [3:0]  e_id;
    opnd_t       e_o1, e_o2;
    idle_inputs();
    rst = 1;
    step();
    rst = 0;
    m_valid = 0; e_strobes = 0;
    m_op = 0; m_rd = 0; m_rs1 = 0; m_rs2 = 0; m_u1 = 0; m_u2 = 0; m_wr = 0; m_ls = 0;
    m_imm = 0; m_pc = 0; e_id = 0; e_o1 = '0; e_o2 = '0;
    for (int n = 0; n < 400; n++) begin
      rdy = ($urandom_range(0, 9) != 0);
      clear = ($urandom_range(0, 19) == 0);
      rob_full = ($urandom_range(0, 4) == 0);
      rs_full = ($urandom_range(0, 3) == 0);
      lsb_full = ($urandom_range(0, 3) == 0);
      inst_valid = ($urandom_range(0, 9) < 7);
      inst_opcode = 6'($urandom); inst_rd = 5'($urandom_range(0, 3));
      inst_rs1 = 5'($urandom_range(0, 3)); inst_rs2 = 5'($urandom_range(0, 3));
      inst_use_rs1 = 1'($urandom); inst_use_rs2 = 1'($urandom);
      inst_wr_rd = 1'($urandom); inst_is_ls = 1'($urandom);
      inst_imm = $urandom; inst_pc = $urandom;
      rf_val1 = $urandom; rf_val2 = $urandom;
      rf_busy1 = 1'($urandom); rf_busy2 = 1'($urandom);
      rf_tag1 = 4'($urandom); rf_tag2 = 4'($urandom);
      rob_rdy1 = 1'($urandom); rob_rdy2 = 1'($urandom);
      rob_val1 = $urandom; rob_val2 = $urandom; rob_tail = 4'($urandom);
      is_alu_ok = 1'($urandom); is_lsb_ok = 1'($urandom);
      rob_id_from_alu = $urandom_range(0, 1) ? rf_tag2 : 4'($urandom);
      rob_id_from_lsb = $urandom_range(0, 1) ? rf_tag1 : 4'($urandom);
      res_from_alu = $urandom; res_from_lsb = $urandom;
      #1;
      m_fire = m_valid && rdy && !clear && !rob_full && !(m_ls ? lsb_full : rs_full);
      m_ready = !m_valid || m_fire;
      m_accept = inst_valid && m_ready && rdy && !clear;
      checks++;
      if (inst_ready !== m_ready || rob_q1 !== rf_tag1 || rob_q2 !== rf_tag2 ||
          (m_valid && (rf_rs1 !== m_rs1 || rf_rs2 !== m_rs2))) begin
        errors++; $display("FAIL rnd_comb: n=%0d ready=%b exp %b rs1=%0d exp %0d", n,
                           inst_ready, m_ready, rf_rs1, m_rs1);
      end
      fired = m_fire;
      if (m_fire) begin
        e_id = rob_tail;
        e_o1 = ref_operand(m_u1, m_rs1, rf_busy1, rf_val1, rf_tag1, rob_rdy1, rob_val1);
        e_o2 = ref_operand(m_u2, m_rs2, rf_busy2, rf_val2, rf_tag2, rob_rdy2, rob_val2);
      end
      if (clear) e_strobes = 4'b0;
      else if (rdy) e_strobes = {m_fire && !m_ls, m_fire && m_ls, m_fire,
                                 m_fire && m_wr && m_rd != 0};
      step();
      checks++;
      if ({is_issue, lsb_issue, rob_alloc_en, rename_en} !== e_strobes) begin
        errors++; $display("FAIL rnd_strobes: n=%0d got %b exp %b", n,
                           {is_issue, lsb_issue, rob_alloc_en, rename_en}, e_strobes);
      end
      if (fired) begin
        checks++;
        if (issue_rob_id !== e_id || {issue_Ri, issue_Qi, issue_Vi} !== e_o1 ||
            {issue_Rj, issue_Qj, issue_Vj} !== e_o2 || issue_opcode !== m_op ||
            issue_imm !== m_imm || issue_pc !== m_pc || rob_rd !== m_rd ||
            rob_pc !== m_pc || rob_opcode !== m_op ||
            (e_strobes[0] && (rename_rd !== m_rd || rename_tag !== e_id))) begin
          errors++; $display("FAIL rnd_packet: n=%0d id=%0d exp %0d op1=%h exp %h op2=%h exp %h",
                             n, issue_rob_id, e_id, {issue_Ri, issue_Qi, issue_Vi}, e_o1,
                             {issue_Rj, issue_Qj, issue_Vj}, e_o2);
        end
      end
      if (clear) m_valid = 0;
      else if (m_accept) begin
        m_valid = 1; m_op = inst_opcode; m_rd = inst_rd; m_rs1 = inst_rs1; m_rs2 = inst_rs2;
        m_u1 = inst_use_rs1; m_u2 = inst_use_rs2; m_wr = inst_wr_rd; m_ls = inst_is_ls;
        m_imm = inst_imm; m_pc = inst_pc;
      end else if (m_fire) m_valid = 0;
    end
  endtask

  initial begin
    idle_inputs();
    #1;
    test_reset();
    test_alu_operands(1'b0);
    test_alu_operands(1'b1);
    test_lsb_stall();
    test_rob_full();
    test_back_to_back();
    test_clear();
    test_rd_zero();
    test_rst_mid_stall();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dispatcher.md
DISPATCHER -- requirements
Module: dispatcher

Interface
REQ-001 SHALL state: one clock; reset is synchronous and active-high.
REQ-002 clk  in  1  clock; rst  in  1  synchronous active-high reset.
REQ-003 rdy  in  1  global enable (low: freeze all state); clear  in  1  flush (mispredict).
REQ-004 Decoder side: inst_valid in 1; inst_ready out 1; inst_opcode in 6; inst_rd/inst_rs1/inst_rs2 in 5 each; inst_use_rs1/inst_use_rs2/inst_wr_rd/inst_is_ls in 1 each; inst_imm/inst_pc in 32 each.
REQ-005 Regfile side: rf_rs1/rf_rs2 out 5 (comb addr); rf_val1/rf_val2 in 32; rf_busy1/rf_busy2 in 1; rf_tag1/rf_tag2 in 4; rename_en out 1; rename_rd out 5; rename_tag out 4.
REQ-006 ROB side: rob_full in 1; rob_tail in 4 (next id); rob_q1/rob_q2 out 4 (comb); rob_rdy1/rob_rdy2 in 1; rob_val1/rob_val2 in 32; rob_alloc_en out 1; rob_opcode out 6; rob_rd out 5; rob_pc out 32.
REQ-007 RS/LSB side: rs_full/lsb_full in 1; is_issue/lsb_issue out 1; issue_opcode 6, issue_rob_id 4, issue_Vi/issue_Vj 32, issue_Qi/issue_Qj 4, issue_Ri/issue_Rj 1, issue_imm/issue_pc 32: all out, registered, shared by RS and LSB.
REQ-008 Broadcast: is_alu_ok/is_lsb_ok in 1; rob_id_from_alu/rob_id_from_lsb in 4; res_from_alu/res_from_lsb in 32.

Function
REQ-009 Single-entry hold register (hold_valid + latched inst fields); states EMPTY (hold_valid=0), HELD (hold_valid=1).
REQ-010 inst_ready = !hold_valid || fire (combinational); accept = inst_valid && inst_ready && rdy && !clear.
REQ-011 target_full = inst_is_ls(held) ? lsb_full : rs_full; fire = hold_valid && rdy && !clear && !rob_full && !target_full.
REQ-012 Transitions: EMPTY+accept -> HELD; HELD+fire+!accept -> EMPTY; HELD+fire+accept -> HELD (new inst); HELD+!fire -> HELD (stall, fields stable).
REQ-013 On fire, next edge: exactly one of is_issue (non-LS) / lsb_issue (LS) =1 for one cycle; rob_alloc_en=1; issue_rob_id=rob_tail sampled at fire; rob_opcode/rob_rd/rob_pc from hold.
REQ-014 On fire with inst_wr_rd && rd!=0: rename_en=1, rename_rd=rd, rename_tag=rob_tail, same cycle as rob_alloc_en; rd==0 -> rename_en=0.
REQ-015 Operand resolution per source (evaluated in fire cycle), first match wins: (a) !use or rs==0 -> R=1,V=0,Q=0; (b) !rf_busy -> R=1,V=rf_val; (c) is_alu_ok && rob_id_from_alu==rf_tag -> R=1,V=res_from_alu; (d) is_lsb_ok && rob_id_from_lsb==rf_tag -> R=1,V=res_from_lsb; (e) rob_rdy -> R=1,V=rob_val; (f) else R=0,Q=rf_tag,V=0.
REQ-016 rob_q1/rob_q2 = rf_tag1/rf_tag2; rf_rs1/rf_rs2 driven from hold fields.
REQ-017 Whenever R=1, Q SHALL be 0.
REQ-018 issue_imm/issue_pc/issue_opcode copied unmodified from hold.
REQ-019 No fire -> all strobes (is_issue, lsb_issue, rob_alloc_en, rename_en) 0 next edge; data outputs MAY hold stale values.
REQ-020 clear: hold_valid<=0, all strobes <=0 next edge, in-progress fire suppressed, decoder input that cycle discarded.
REQ-021 rdy=0: no state change, strobes keep previous value; inst_ready may be high but no accept occurs.
REQ-022 Throughput: one instruction per cycle when no stall; latency accept->issue strobe = 2 edges.

Reset
REQ-023 rst (priority over clear/rdy): hold_valid=0, is_issue=0, lsb_issue=0, rob_alloc_en=0, rename_en=0, all data outputs 0; inst_ready=1 first cycle after reset.

Verification
REQ-024 ALU op, rs1 regfile not busy (val 5), rs2 busy tag 3, ROB entry 3 not ready, rob_tail=7 -> is_issue=1, Vi=5,Ri=1, Qj=3,Rj=0, issue_rob_id=7, rename_tag=7.
REQ-025 Same, with is_alu_ok=1, rob_id_from_alu=3, res=0x10 in fire cycle -> Rj=1, Vj=0x10, Qj=0.
REQ-026 Load held with lsb_full=1 for 3 cycles -> inst_ready=0, no strobes; lsb_full drops -> lsb_issue=1 once, is_issue=0.
REQ-027 rob_full=1 with valid inst -> no rob_alloc_en, no issue; back-to-back 4 ALU insts, no stall -> 4 consecutive is_issue pulses, rob ids 0,1,2,3.
REQ-028 clear asserted while HELD -> next edge hold empty, no strobes; rd=0 writer -> rename_en=0; rst mid-stall -> all strobes 0, inst_ready=1.
